fmul_share_arbiter: RTL



---
 rtl/fmul_share_pkg.sv | 35 +++
 rtl/fmul_rsp_fifo.sv | 59 +++++
 rtl/fmul_share_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fmul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// Tag ids are sized for the largest supported requester count (8).
package fmul_share_pkg;

    localparam int FP_W     = 64;
    localparam int DEF_LAT  = 14;
    localparam int NREQ_MAX = 8;
    localparam int ID_W     = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Round-robin search starting just after ptr; returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(
        input logic [NREQ_MAX-1:0] elig,
        input logic [ID_W-1:0]     ptr,
        input int unsigned         nreq
    );
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
            if (k <= nreq) begin
                idx = ID_W'((32'(ptr) + k) % nreq);
                if (!res[ID_W] && elig[idx]) begin
                    res = {1'b1, idx};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fmul_rsp_fifo.sv
// First-word-fall-through response FIFO; the head reads as zero when empty.
// The caller guarantees that a push never lands on a full FIFO without a pop.
module fmul_rsp_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_pop;

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == CW'(DEPTH));
    assign count  = count_reg;
    assign do_pop = pop & ~empty;
    assign rdata  = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fmul_share_arbiter.sv
// Round-robin sharing of one non-stallable pipelined multiplier; a credit per
// response-FIFO slot keeps every in-flight result guaranteed a landing place.
module fmul_share_arbiter
    import fmul_share_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int LAT       = DEF_LAT,
    parameter int RSP_DEPTH = 4,
    parameter int W         = FP_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [NREQ*W-1:0] rsp_data,
    output logic [W-1:0]      mul_num1,
    output logic [W-1:0]      mul_num2,
    output logic              mul_valid,
    input  logic [W-1:0]      mul_result,
    input  logic              mul_ready,
    output logic              busy,
    output logic              err_tag
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] push_vec;
    logic [NREQ-1:0] fifo_empty;
    logic [NREQ-1:0] fifo_full;
    logic [CW-1:0]   fifo_count [NREQ];
    logic [ID_W:0]   pick;
    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            inflight_any;
    logic            any_stored;
    tag_t            tag_out;
    logic            tag_push;

    logic [ID_W-1:0] rr_ptr_reg;
    logic [CW-1:0]   credit_reg [NREQ];
    tag_t            tag_pipe_reg [LAT+1];
    logic [W-1:0]    mul_num1_reg;
    logic [W-1:0]    mul_num2_reg;
    logic            mul_valid_reg;
    logic            busy_reg;
    logic            err_tag_reg;

    assign pick      = rr_pick(NREQ_MAX'(elig), rr_ptr_reg, NREQ);
    assign grant_any = pick[ID_W];
    assign grant_idx = pick[ID_W-1:0];
    assign req_ready = grant;

    assign tag_out  = tag_pipe_reg[LAT];
    assign tag_push = mul_ready & tag_out.valid;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            // Gating with rstn keeps req_ready low while reset is held.
            assign elig[gi]     = rstn & req_valid[gi] & (credit_reg[gi] != '0);
            assign grant[gi]    = grant_any & (grant_idx == ID_W'(gi));
            assign pop[gi]      = ~fifo_empty[gi] & rsp_ready[gi];
            assign push_vec[gi] = tag_push & (tag_out.id == ID_W'(gi))
                                  & (~fifo_full[gi] | pop[gi]);
            assign rsp_valid[gi] = ~fifo_empty[gi];

            fmul_rsp_fifo #(
                .W     (W),
                .DEPTH (RSP_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rstn  (rstn),
                .push  (push_vec[gi]),
                .pop   (pop[gi]),
                .wdata (mul_result),
                .rdata (rsp_data[gi*W +: W]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi]),
                .count (fifo_count[gi])
            );
        end
    endgenerate

    always_comb begin
        sel_a        = '0;
        sel_b        = '0;
        inflight_any = 1'b0;
        any_stored   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
            any_stored = any_stored | (fifo_count[i] != '0);
        end
        for (int j = 0; j <= LAT; j++) begin
            inflight_any = inflight_any | tag_pipe_reg[j].valid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_reg    <= ID_W'(NREQ - 1);
            mul_num1_reg  <= '0;
            mul_num2_reg  <= '0;
            mul_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_tag_reg   <= 1'b0;
            for (int j = 0; j <= LAT; j++) begin
                tag_pipe_reg[j] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                credit_reg[i] <= CW'(RSP_DEPTH);
            end
        end else begin
            mul_valid_reg <= grant_any;
            if (grant_any) begin
                rr_ptr_reg   <= grant_idx;
                mul_num1_reg <= sel_a;
                mul_num2_reg <= sel_b;
            end
            tag_pipe_reg[0] <= '{valid: grant_any, id: grant_idx};
            for (int j = 1; j <= LAT; j++) begin
                tag_pipe_reg[j] <= tag_pipe_reg[j-1];
            end
            // A result without a tag, or a tag without a result, is never pushed.
            if (mul_ready != tag_out.valid) begin
                err_tag_reg <= 1'b1;
            end
            busy_reg <= inflight_any | any_stored;
            for (int i = 0; i < NREQ; i++) begin
                case ({grant[i], pop[i]})
                    2'b10:   credit_reg[i] <= credit_reg[i] - CW'(1);
                    2'b01:   credit_reg[i] <= credit_reg[i] + CW'(1);
                    default: credit_reg[i] <= credit_reg[i];
                endcase
            end
        end
    end

    assign mul_num1  = mul_num1_reg;
    assign mul_num2  = mul_num2_reg;
    assign mul_valid = mul_valid_reg;
    assign busy      = busy_reg;
    assign err_tag   = err_tag_reg;

endmodule
